morph_blob_stats: RTL and testbench
===================================

# morph_blob_stats

Downstream stage of the 3x3 morphological filter in the camera pipeline: consumes the filtered 10-bit mask stream and, per frame, reports the foreground bounding box, pixel count and integer centroid. Results feed the VGA overlay and the tracking logic. Pixels arrive in raster order qualified by `iDVAL`; a start-of-frame pulse resynchronises position counters.

## Interface
- `IMG_W`, 640: active pixels per line
- `IMG_H`, 480: active lines per frame
- `THRESH`, 10'h200: pixel is foreground when `iDATA >= THRESH`
- `MIN_COUNT`, 16: minimum foreground pixels for `oFOUND=1`

- `CLOCK` in 1: pixel clock
- `RESET` in 1: synchronous, active-high
- `iSOF` in 1: start-of-frame pulse, coincident with or before the first `iDVAL` of a frame
- `iDVAL` in 1: pixel valid
- `iDATA` in 10: filtered mask pixel
- `oBOX_VALID` out 1: one-cycle result strobe
- `oFOUND` out 1: count >= `MIN_COUNT`
- `oX_MIN`, `oX_MAX`, `oY_MIN`, `oY_MAX` out 10 each: bounding box, inclusive
- `oCX`, `oCY` out 10 each: centroid, floor(sum/count)
- `oCOUNT` out 19: foreground pixel count
- `oOVERRUN` out 1: one-cycle pulse, a frame result was dropped

## Operation
- Position: `x`, `y` counters. On `iDVAL`: process pixel at (x,y), then x++, and on x=`IMG_W`-1 wrap x to 0 and y++. `iSOF` clears x, y and all accumulators; an `iSOF` arriving in the same cycle as `iDVAL` applies first, so that pixel is (0,0).
- Accumulators, updated on foreground pixels only: xmin/ymin init 1023, xmax/ymax init 0, sum_x and sum_y (28 bits each), count (19 bits).
- Frame end: a valid pixel at (`IMG_W`-1,`IMG_H`-1). On the next edge, copy the accumulators, including that last pixel, into snapshot registers. In the same edge, re-init the accumulators and x/y.
- FSM states:
  - ACCUM: always accepting pixels.
  - DIV: two `seq_udiv` instances compute sum_x/count and sum_y/count in parallel. Pixel accumulation continues unaffected while in DIV.
  - DONE: drive outputs and strobe, then return to ACCUM.
- count < `MIN_COUNT`:
  - `oFOUND=0`.
  - Box, centroid and `oCOUNT` outputs are forced to 0.
  - Division is skipped, but the strobe arrives at the same latency.
- count = 0: never divide. Division by zero is impossible by the rule above, since `MIN_COUNT` >= 1.
- Frame end while in DIV or DONE:
  - The new frame is dropped.
  - `oOVERRUN` pulses in the frame-end cycle + 1.
  - Accumulators are still re-initialised.
  - The in-flight result completes normally.
- `iSOF` mid-frame: discards the partial frame. Any in-flight division completes normally.
- Outputs hold their last value until the next strobe.
- `iDVAL` low: counters and accumulators hold.

## Timing
- Reset: every output is 0, the FSM is in ACCUM, x/y are 0, and accumulators are at their init values.
- Let T be the edge sampling the last pixel of a frame.
  - Snapshot is loaded and the divider starts at T+1.
  - The 28 restoring iterations run on T+2..T+29.
  - Outputs are registered and `oBOX_VALID`=1 at T+30, for exactly one cycle.
- Minimum line and frame blanking is not required.
- Frames shorter than 30 pixels overrun by construction.
- All outputs are registered, with no combinational path from inputs.

## Structure
- Package `morph_pkg`:
  - constants `PIX_W`=10, `SUM_W`=28, `CNT_W`=19
  - FSM state enum {ACCUM, DIV, DONE}
- Sub-module `seq_udiv`, parameterised by dividend and divisor widths:
  - start/busy/done handshake
  - one quotient bit per cycle
  - 10-bit quotient output, truncated; the quotient is guaranteed < 1024
- The top level holds the counters, accumulators, snapshot, FSM and output registers.

## Test plan
- 640x480 frame, single foreground pixel at (100,50), `MIN_COUNT`=1 -> `oFOUND`=1, box=(100,100,50,50), centroid (100,50), `oCOUNT`=1, strobe at T+30.
- Solid rectangle x 10..19, y 20..29 (100 pixels) -> box (10,19,20,29), centroid (14,24), `oCOUNT`=100.
- All-zero frame -> `oFOUND`=0, all data outputs 0, strobe still at T+30. 10 foreground pixels with `MIN_COUNT`=16 -> same response.
- Pixel with `iDATA`=10'h1FF vs 10'h200 at the same location -> only the 10'h200 pixel counts.
- `iSOF` at line 240 after foreground pixels in lines 0..239, then a clean frame containing the single pixel (5,5) -> reported result reflects only (5,5).
- `IMG_W`=8, `IMG_H`=2 with back-to-back frames -> second frame dropped, `oOVERRUN` pulses at its end+1, first result is correct; `RESET` asserted mid-DIV -> all outputs 0 next cycle, no strobe.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared constants and FSM state type for the blob statistics stage.
package morph_pkg;

    localparam int PIX_W = 10;
    localparam int SUM_W = 28;
    localparam int CNT_W = 19;

    typedef enum logic [1:0] {
        ACCUM,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle.
module seq_udiv #(
    parameter int DW = 28,
    parameter int VW = 19,
    parameter int QW = 10
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] q;
    logic [VW-1:0] d;
    logic [VW-1:0] r;
    logic [CW-1:0] cnt;
    logic [VW:0]   trial;
    logic [VW:0]   diff;

    // A borrow out of the top bit means the trial remainder is below the divisor
    assign trial    = {r, q[DW-1]};
    assign diff     = trial - {1'b0, d};
    assign quotient = q[QW-1:0];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            q    <= '0;
            d    <= '0;
            r    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q    <= dividend;
                d    <= divisor;
                r    <= '0;
                cnt  <= CW'(DW);
                busy <= 1'b1;
            end else if (busy) begin
                if (!diff[VW]) begin
                    r <= diff[VW-1:0];
                    q <= {q[DW-2:0], 1'b1};
                end else begin
                    r <= trial[VW-1:0];
                    q <= {q[DW-2:0], 1'b0};
                end
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/morph_blob_stats.sv
// Per-frame foreground bounding box, pixel count and centroid of the mask stream.
module morph_blob_stats
    import morph_pkg::*;
#(
    parameter int               IMG_W     = 640,
    parameter int               IMG_H     = 480,
    parameter logic [PIX_W-1:0] THRESH    = 10'h200,
    parameter int               MIN_COUNT = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             iSOF,
    input  logic             iDVAL,
    input  logic [PIX_W-1:0] iDATA,
    output logic             oBOX_VALID,
    output logic             oFOUND,
    output logic [PIX_W-1:0] oX_MIN,
    output logic [PIX_W-1:0] oX_MAX,
    output logic [PIX_W-1:0] oY_MIN,
    output logic [PIX_W-1:0] oY_MAX,
    output logic [PIX_W-1:0] oCX,
    output logic [PIX_W-1:0] oCY,
    output logic [CNT_W-1:0] oCOUNT,
    output logic             oOVERRUN
);

    state_t           state;
    logic [PIX_W-1:0] x, y, px, py;
    logic [PIX_W-1:0] a_xmin, a_xmax, a_ymin, a_ymax;
    logic [SUM_W-1:0] a_sx, a_sy;
    logic [CNT_W-1:0] a_cnt;
    logic [PIX_W-1:0] b_xmin, b_xmax, b_ymin, b_ymax;
    logic [SUM_W-1:0] b_sx, b_sy;
    logic [CNT_W-1:0] b_cnt;
    logic [PIX_W-1:0] s_xmin, s_xmax, s_ymin, s_ymax;
    logic [CNT_W-1:0] s_cnt;
    logic             s_found, fend_q;
    logic             fg, restart, eol, eof;
    logic             take, found_now, div_go, fin;
    logic [4:0]       lat;
    logic             bx_busy, by_busy, bx_done, by_done;
    logic [PIX_W-1:0] qx, qy;

    // Start of frame or a completed frame restarts accumulation from init values
    always_comb begin
        px      = iSOF ? '0 : x;
        py      = iSOF ? '0 : y;
        fg      = iDVAL && (iDATA >= THRESH);
        restart = iSOF || fend_q;
        eol     = (px == PIX_W'(IMG_W - 1));
        eof     = iDVAL && eol && (py == PIX_W'(IMG_H - 1));
        b_xmin  = restart ? '1 : a_xmin;
        b_xmax  = restart ? '0 : a_xmax;
        b_ymin  = restart ? '1 : a_ymin;
        b_ymax  = restart ? '0 : a_ymax;
        b_sx    = restart ? '0 : a_sx;
        b_sy    = restart ? '0 : a_sy;
        b_cnt   = restart ? '0 : a_cnt;
    end

    assign take      = fend_q && (state == ACCUM);
    assign found_now = (a_cnt >= CNT_W'(MIN_COUNT));
    assign div_go    = take && found_now && !(bx_busy || by_busy);
    assign fin       = s_found ? (bx_done && by_done) : (lat == '0);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            x      <= '0;
            y      <= '0;
            fend_q <= 1'b0;
            a_xmin <= '1;
            a_xmax <= '0;
            a_ymin <= '1;
            a_ymax <= '0;
            a_sx   <= '0;
            a_sy   <= '0;
            a_cnt  <= '0;
        end else begin
            fend_q <= eof;
            if (iDVAL) begin
                x <= eol ? '0 : px + 1'b1;
                if (eol)
                    y <= (py == PIX_W'(IMG_H - 1)) ? '0 : py + 1'b1;
                else
                    y <= py;
            end else if (iSOF) begin
                x <= '0;
                y <= '0;
            end
            a_xmin <= (fg && px < b_xmin) ? px : b_xmin;
            a_xmax <= (fg && px > b_xmax) ? px : b_xmax;
            a_ymin <= (fg && py < b_ymin) ? py : b_ymin;
            a_ymax <= (fg && py > b_ymax) ? py : b_ymax;
            a_sx   <= b_sx + (fg ? SUM_W'(px) : '0);
            a_sy   <= b_sy + (fg ? SUM_W'(py) : '0);
            a_cnt  <= b_cnt + CNT_W'(fg);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= ACCUM;
            lat        <= '0;
            s_found    <= 1'b0;
            s_xmin     <= '0;
            s_xmax     <= '0;
            s_ymin     <= '0;
            s_ymax     <= '0;
            s_cnt      <= '0;
            oBOX_VALID <= 1'b0;
            oFOUND     <= 1'b0;
            oX_MIN     <= '0;
            oX_MAX     <= '0;
            oY_MIN     <= '0;
            oY_MAX     <= '0;
            oCX        <= '0;
            oCY        <= '0;
            oCOUNT     <= '0;
            oOVERRUN   <= 1'b0;
        end else begin
            oBOX_VALID <= 1'b0;
            oOVERRUN   <= fend_q && (state != ACCUM);
            unique case (state)
                ACCUM: begin
                    if (take) begin
                        // Small blobs snapshot as zeros so outputs need no gating
                        s_found <= found_now;
                        s_xmin  <= found_now ? a_xmin : '0;
                        s_xmax  <= found_now ? a_xmax : '0;
                        s_ymin  <= found_now ? a_ymin : '0;
                        s_ymax  <= found_now ? a_ymax : '0;
                        s_cnt   <= found_now ? a_cnt : '0;
                        lat     <= 5'(SUM_W);
                        state   <= DIV;
                    end
                end
                DIV: begin
                    if (lat != '0)
                        lat <= lat - 1'b1;
                    if (fin) begin
                        oBOX_VALID <= 1'b1;
                        oFOUND     <= s_found;
                        oX_MIN     <= s_xmin;
                        oX_MAX     <= s_xmax;
                        oY_MIN     <= s_ymin;
                        oY_MAX     <= s_ymax;
                        oCOUNT     <= s_cnt;
                        oCX        <= s_found ? qx : '0;
                        oCY        <= s_found ? qy : '0;
                        state      <= DONE;
                    end
                end
                DONE:    state <= ACCUM;
                default: state <= ACCUM;
            endcase
        end
    end

    seq_udiv #(.DW(SUM_W), .VW(CNT_W), .QW(PIX_W)) u_div_x (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .start    (div_go),
        .dividend (a_sx),
        .divisor  (a_cnt),
        .busy     (bx_busy),
        .done     (bx_done),
        .quotient (qx)
    );

    seq_udiv #(.DW(SUM_W), .VW(CNT_W), .QW(PIX_W)) u_div_y (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .start    (div_go),
        .dividend (a_sy),
        .divisor  (a_cnt),
        .busy     (by_busy),
        .done     (by_done),
        .quotient (qy)
    );

endmodule

// File: tb/tb_morph_blob_stats.sv
// Directed bench: a 104x52 instance (MIN_COUNT=1) and an 8x2 instance (MIN_COUNT=16).
module tb_morph_blob_stats;

    localparam int AW = 104;
    localparam int AH = 52;
    localparam int BW = 8;
    localparam int BH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_sof, a_dval;
    logic [9:0]  a_data;
    logic        a_valid, a_found, a_ovr;
    logic [9:0]  a_xmin, a_xmax, a_ymin, a_ymax, a_cx, a_cy;
    logic [18:0] a_cnt;

    logic        b_rst, b_sof, b_dval;
    logic [9:0]  b_data;
    logic        b_valid, b_found, b_ovr;
    logic [9:0]  b_xmin, b_xmax, b_ymin, b_ymax, b_cx, b_cy;
    logic [18:0] b_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int t_end   = 0;
    int t1      = 0;
    bit seen;

    morph_blob_stats #(.IMG_W(AW), .IMG_H(AH), .MIN_COUNT(1)) dut_a (
        .CLOCK(clk), .RESET(a_rst), .iSOF(a_sof), .iDVAL(a_dval),
        .iDATA(a_data), .oBOX_VALID(a_valid), .oFOUND(a_found),
        .oX_MIN(a_xmin), .oX_MAX(a_xmax), .oY_MIN(a_ymin),
        .oY_MAX(a_ymax), .oCX(a_cx), .oCY(a_cy), .oCOUNT(a_cnt),
        .oOVERRUN(a_ovr)
    );

    morph_blob_stats #(.IMG_W(BW), .IMG_H(BH), .MIN_COUNT(16)) dut_b (
        .CLOCK(clk), .RESET(b_rst), .iSOF(b_sof), .iDVAL(b_dval),
        .iDATA(b_data), .oBOX_VALID(b_valid), .oFOUND(b_found),
        .oX_MIN(b_xmin), .oX_MAX(b_xmax), .oY_MIN(b_ymin),
        .oY_MAX(b_ymax), .oCX(b_cx), .oCY(b_cy), .oCOUNT(b_cnt),
        .oOVERRUN(b_ovr)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [9:0] fa(input int k, input int x, input int y);
        case (k)
            0: return (x == 100 && y == 50) ? 10'h200 : 10'h000;
            1: return (x >= 10 && x <= 19 && y >= 20 && y <= 29) ? 10'h3FF : 10'h000;
            2: return (x == 100 && y == 50) ? 10'h1FF : 10'h000;
            3: return (x == 5 && y == 5) ? 10'h200 : 10'h000;
            default: return 10'h3FF;
        endcase
    endfunction

    task automatic send_a(input int k, input int nl);
        for (int yy = 0; yy < nl; yy++) begin
            for (int xx = 0; xx < AW; xx++) begin
                a_sof  = (xx == 0 && yy == 0);
                a_dval = 1'b1;
                a_data = fa(k, xx, yy);
                step();
            end
        end
        a_sof  = 1'b0;
        a_dval = 1'b0;
        a_data = '0;
        t_end  = cyc;
    endtask

    // kind 0: ten pixels (x<5 on both rows); kind 1: every pixel foreground
    task automatic send_b(input int k);
        for (int yy = 0; yy < BH; yy++) begin
            for (int xx = 0; xx < BW; xx++) begin
                b_sof  = (xx == 0 && yy == 0);
                b_dval = 1'b1;
                b_data = (k == 1 || xx < 5) ? 10'h3FF : 10'h000;
                step();
            end
        end
        b_sof  = 1'b0;
        b_dval = 1'b0;
        b_data = '0;
        t_end  = cyc;
    endtask

    task automatic wait_res(input string tag, input bit sel);
        while ((sel ? b_valid : a_valid) !== 1'b1 && cyc - t_end < 40)
            step();
        chk({tag, "_latency"}, cyc - t_end, 30);
    endtask

    task automatic chk_res(input string tag, input bit sel,
                           input logic [31:0] f, x0, x1, y0, y1, cx, cy, n);
        chk({tag, "_found"}, sel ? b_found : a_found, f);
        chk({tag, "_xmin"}, sel ? b_xmin : a_xmin, x0);
        chk({tag, "_xmax"}, sel ? b_xmax : a_xmax, x1);
        chk({tag, "_ymin"}, sel ? b_ymin : a_ymin, y0);
        chk({tag, "_ymax"}, sel ? b_ymax : a_ymax, y1);
        chk({tag, "_cx"}, sel ? b_cx : a_cx, cx);
        chk({tag, "_cy"}, sel ? b_cy : a_cy, cy);
        chk({tag, "_count"}, sel ? b_cnt : a_cnt, n);
        step();
        chk({tag, "_strobe_width"}, sel ? b_valid : a_valid, 0);
    endtask

    initial begin
        a_rst = 1'b1; a_sof = 1'b0; a_dval = 1'b0; a_data = '0;
        b_rst = 1'b1; b_sof = 1'b0; b_dval = 1'b0; b_data = '0;
        step();
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_ovr", a_ovr, 0);
        chk("rst_b_valid", b_valid, 0);
        chk_res("rst_a", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        send_a(0, AH);
        wait_res("pix", 1'b0);
        chk_res("pix", 1'b0, 1, 100, 100, 50, 50, 100, 50, 1);

        send_a(1, AH);
        wait_res("rect", 1'b0);
        chk_res("rect", 1'b0, 1, 10, 19, 20, 29, 14, 24, 100);

        send_a(2, AH);
        wait_res("thr1ff", 1'b0);
        chk_res("thr1ff", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        send_a(4, 26);
        send_a(3, AH);
        wait_res("sof", 1'b0);
        chk_res("sof", 1'b0, 1, 5, 5, 5, 5, 5, 5, 1);

        send_b(0);
        wait_res("small", 1'b1);
        chk_res("small", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

        send_b(1);
        t1 = t_end;
        send_b(1);
        chk("ovr_idle", b_ovr, 0);
        step();
        chk("ovr_pulse", b_ovr, 1);
        step();
        chk("ovr_clear", b_ovr, 0);
        t_end = t1;
        wait_res("b2b", 1'b1);
        chk_res("b2b", 1'b1, 1, 0, 7, 0, 1, 3, 0, 16);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (b_valid === 1'b1) seen = 1'b1;
        end
        chk("drop_no_strobe", seen, 0);

        send_b(1);
        repeat (10) step();
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        chk("midrst_valid", b_valid, 0);
        chk("midrst_found", b_found, 0);
        chk("midrst_xmax", b_xmax, 0);
        chk("midrst_ymax", b_ymax, 0);
        chk("midrst_cx", b_cx, 0);
        chk("midrst_count", b_cnt, 0);
        chk("midrst_ovr", b_ovr, 0);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (b_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_strobe", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
